// File: rtl/des_feistel_f.sv
// des_feistel_f
//   DES round function f(R, K): E-expansion of the 32-bit right half, XOR
//   with the 48-bit round subkey, eight 6->4 S-box lookups and the 32-bit
//   P permutation. The whole chain is combinational. The result and every
//   intermediate tap are registered on edges where in_valid is high, so
//   the latency is one cycle.
//
//   Bit numbering: DES bit n of a W-bit bus is index W-n (DES bit 1 = MSB).
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset; clears every output
//   in_valid  in   1   r_in/subkey valid this cycle
//   r_in      in  32   right half R
//   subkey    in  48   round key K
//   out_valid out  1   registered outputs hold a new result
//   e_out     out 48   E(R)
//   x_out     out 48   E(R) ^ K
//   s_out     out 32   S-box outputs, S1 in [31:28] ... S8 in [3:0]
//   f_out     out 32   P(S), the f-function result
module des_feistel_f (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  output logic [47:0] e_out,
  output logic [47:0] x_out,
  output logic [31:0] s_out,
  output logic [31:0] f_out
);

  // Each box holds 64 nibbles, entry {row, col} at bits [255-4*entry -: 4].
  localparam logic [255:0] S_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Group g (0-based) of E(R) is DES bits 4g .. 4g+5 of R, where bit 0
  // wraps to 32 and bit 33 wraps to 1.
  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] e;
    int          n;
    e = '0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 6; j++) begin
        n = ((4 * g + j + 31) % 32) + 1;
        e[47 - (6 * g + j)] = r[32 - n];
      end
    end
    return e;
  endfunction

  // Row is the outer bit pair {b1, b6}, column the inner four bits.
  function automatic logic [3:0] sbox(input int b, input logic [5:0] x);
    logic [5:0] a;
    a = {x[5], x[0], x[4:1]};
    return S_TAB[b][255 - 4 * int'(a) -: 4];
  endfunction

  function automatic logic [31:0] permute(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      p[31 - i] = s[32 - P_TAB[i]];
    end
    return p;
  endfunction

  logic [47:0] e_p0;
  logic [47:0] x_p0;
  logic [31:0] s_p0;
  logic [31:0] f_p0;

  logic        vld_p1;
  logic [47:0] e_p1;
  logic [47:0] x_p1;
  logic [31:0] s_p1;
  logic [31:0] f_p1;

  // ---- stage 0: combinational E -> XOR -> S -> P ----
  always_comb begin
    e_p0 = expand(r_in);
    x_p0 = e_p0 ^ subkey;
    s_p0 = '0;
    for (int b = 0; b < 8; b++) begin
      s_p0[31 - 4 * b -: 4] = sbox(b, x_p0[47 - 6 * b -: 6]);
    end
    f_p0 = permute(s_p0);
  end

  // ---- stage 1: output registers, loaded only on accepted inputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      e_p1   <= '0;
      x_p1   <= '0;
      s_p1   <= '0;
      f_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        e_p1 <= e_p0;
        x_p1 <= x_p0;
        s_p1 <= s_p0;
        f_p1 <= f_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign e_out     = e_p1;
  assign x_out     = x_p1;
  assign s_out     = s_p1;
  assign f_out     = f_p1;

endmodule

// File: tb/tb_des_feistel_f.sv
module tb_des_feistel_f;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] r_in = '0;
  logic [47:0] subkey = '0;
  logic        out_valid;
  logic [47:0] e_out;
  logic [47:0] x_out;
  logic [31:0] s_out;
  logic [31:0] f_out;

  int total = 0;
  int bad = 0;

  des_feistel_f dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .r_in      (r_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .e_out     (e_out),
    .x_out     (x_out),
    .s_out     (s_out),
    .f_out     (f_out)
  );

  always #5 clk = ~clk;

  // Reference tables, written out as in FIPS 46-3.
  int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  int SB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic ref_f(input logic [31:0] r, input logic [47:0] k,
                       output logic [47:0] e, output logic [47:0] x,
                       output logic [31:0] s, output logic [31:0] f);
    logic [5:0] chunk;
    int         row;
    int         col;
    e = '0;
    for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
    x = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      chunk = 6'((x >> (42 - 6 * b)) & 48'h3F);
      row   = 2 * int'(chunk[5]) + int'(chunk[0]);
      col   = int'(chunk[4:1]);
      s     = (s << 4) | 32'(SB[b][row * 16 + col]);
    end
    f = '0;
    for (int i = 0; i < 32; i++) f = (f << 1) | ((s >> (32 - P_T[i])) & 32'h1);
  endtask

  task automatic drive(input logic [31:0] r, input logic [47:0] k, input logic v);
    @(negedge clk);
    r_in     = r;
    subkey   = k;
    in_valid = v;
  endtask

  task automatic check_all(input string tag, input logic [47:0] e, input logic [47:0] x,
                           input logic [31:0] s, input logic [31:0] f, input logic v);
    chk({tag, ".e"}, 64'(e_out), 64'(e));
    chk({tag, ".x"}, 64'(x_out), 64'(x));
    chk({tag, ".s"}, 64'(s_out), 64'(s));
    chk({tag, ".f"}, 64'(f_out), 64'(f));
    chk({tag, ".vld"}, 64'(out_valid), 64'(v));
  endtask

  localparam logic [31:0] R2 = 32'h539A2915;
  localparam logic [47:0] K2 = 48'h547EEE4D443C;

  initial begin
    logic [47:0] me, mx;
    logic [31:0] ms, mf;
    logic [47:0] xe, xx;
    logic [31:0] xs, xf;
    logic        xv;
    logic [63:0] rk;
    logic        v;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, '0, '0, '0, 1'b0);

    // vector 1: all zero
    @(negedge clk);
    rst_n = 1'b1;
    r_in = '0; subkey = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    check_all("v1", '0, '0, 32'hEFA72C4D, 32'hD8D8DBBC, 1'b1);

    // vector 2
    drive(R2, K2, 1'b1);
    @(posedge clk); #1;
    check_all("v2", 48'hAA7CF41528AA, 48'hFE021A586C96, 32'hD06CFFFE, 32'h3BB7B4EF, 1'b1);

    // all-ones R: row 3, column 15 of every box
    drive(32'hFFFFFFFF, 48'h0, 1'b1);
    ref_f(32'hFFFFFFFF, 48'h0, me, mx, ms, mf);
    @(posedge clk); #1;
    check_all("r_ones", 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, mf, 1'b1);

    // all-ones K gives the same XOR value and S output
    drive(32'h0, 48'hFFFFFFFFFFFF, 1'b1);
    @(posedge clk); #1;
    check_all("k_ones", '0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, mf, 1'b1);

    // back-to-back then idle with hold
    drive(32'h0, 48'h0, 1'b1);
    @(posedge clk); #1;
    check_all("b2b1", '0, '0, 32'hEFA72C4D, 32'hD8D8DBBC, 1'b1);
    drive(R2, K2, 1'b1);
    @(posedge clk); #1;
    check_all("b2b2", 48'hAA7CF41528AA, 48'hFE021A586C96, 32'hD06CFFFE, 32'h3BB7B4EF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(32'h12345678, 48'hABCDEF012345, 1'b0);
      @(posedge clk); #1;
      check_all("hold", 48'hAA7CF41528AA, 48'hFE021A586C96, 32'hD06CFFFE, 32'h3BB7B4EF, 1'b0);
    end

    // asynchronous reset between edges
    drive(R2, K2, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    r_in = '0; subkey = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.f", 64'(f_out), 64'h00000000D8D8DBBC);
    chk("post_rst.vld", 64'(out_valid), 64'h1);

    // random sweep with idle gaps against the reference model
    xe = '0; xx = '0; xs = '0; xf = '0;
    for (int i = 0; i < 10000; i++) begin
      rk = {$urandom, $urandom};
      v  = (i == 0) || ($urandom_range(0, 4) != 0);
      drive($urandom, rk[47:0], v);
      if (v) ref_f(r_in, subkey, xe, xx, xs, xf);
      xv = v;
      @(posedge clk); #1;
      check_all("rand", xe, xx, xs, xf, xv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
